fpu_mul_issue: RTL and testbench

Front-end issue controller for the single-precision multiplier. Buffers operand pairs from the FPU dispatch in a small FIFO and issues them one at a time to `fpu_mul` using its valid-pulse / ready-pulse protocol. It captures each product, classifies it, and presents it downstream on a valid/ready handshake with its tag. A watchdog guarantees forward progress if the multiplier never responds.

---
 rtl/fpu_mul_issue.sv | 279 +++++++++++++++++++++++++++
 tb/tb_fpu_mul_issue.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_mul_issue.sv
// fpu_mul_issue
// Issue controller in front of the single-precision multiplier.
// Operand pairs from dispatch are queued in a small circular FIFO. They are
// issued one at a time to fpu_mul using its valid-pulse / ready-pulse
// protocol. Each product is classified and held on a valid/ready output
// together with its tag. A watchdog forces a quiet-NaN result if the
// multiplier never answers, and sets a sticky error flag.
//
// Ports
//   clk, reset            clock (rising edge); asynchronous active-low reset
//   in_valid/in_ready     request handshake; in_ready = (count < DEPTH)
//   in_a, in_b, in_tag    operands and request tag
//   mul_din1, mul_din2    registered operands to the multiplier, held between issues
//   mul_valid             one-cycle issue pulse (asserted only in ISSUE)
//   mul_result, mul_ready product and its one-cycle valid pulse
//   out_valid/out_ready   result handshake
//   out_result, out_tag   product and its tag
//   out_flags             {timeout, nan, inf, zero, subnormal}
//   err                   sticky timeout indicator, cleared only by reset
//   count                 FIFO occupancy
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for a queued request; pops the FIFO head into mul_din*
// ISSUE    | mul_valid high for this cycle; watchdog loaded
// WAIT_RES | waiting for mul_ready or watchdog expiry
// HOLD     | result presented on out_*; waits for out_ready

module fpu_mul_issue #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_a,
    input  logic [31:0]            in_b,
    input  logic [TAG_W-1:0]       in_tag,
    output logic [31:0]            mul_din1,
    output logic [31:0]            mul_din2,
    output logic                   mul_valid,
    input  logic [31:0]            mul_result,
    input  logic                   mul_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_result,
    output logic [TAG_W-1:0]       out_tag,
    output logic [4:0]             out_flags,
    output logic                   err,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WD_W  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(DEPTH);
    localparam logic [WD_W-1:0]  WD_LOAD     = WD_W'(TIMEOUT);
    localparam logic [31:0]      QNAN        = 32'h7FC0_0000;
    localparam logic [4:0]       TIMEOUT_FLG = 5'b11000;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("fpu_mul_issue: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT_RES = 2'd2,
        S_HOLD     = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // FIFO storage and pointers
    logic [31:0]      r_mem_a   [DEPTH];
    logic [31:0]      r_mem_b   [DEPTH];
    logic [TAG_W-1:0] r_mem_tag [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Issue / result registers
    logic [31:0]      r_mul_din1;
    logic [31:0]      r_mul_din2;
    logic [TAG_W-1:0] r_tag;
    logic [WD_W-1:0]  r_wd;
    logic             r_out_valid;
    logic [31:0]      r_out_result;
    logic [TAG_W-1:0] r_out_tag;
    logic [4:0]       r_out_flags;
    logic             r_err;

    // FSM decode
    logic w_push;
    logic w_pop;
    logic w_mul_valid;
    logic w_load_res;
    logic w_timeout;
    logic w_release;

    // Classification of the incoming product
    logic [7:0]  w_exp;
    logic [22:0] w_man;
    logic [3:0]  w_class;

    assign in_ready = (r_count < FULL_CNT);
    assign w_push   = in_valid && in_ready;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    // Storage is not reset: entries are only read after being written,
    // and occupancy is tracked by the reset pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr]   <= in_a;
            r_mem_b[r_wr_ptr]   <= in_b;
            r_mem_tag[r_wr_ptr] <= in_tag;
        end
    end

    // DEPTH is a power of two, so natural pointer overflow is the wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_mul_valid = 1'b0;
        w_load_res  = 1'b0;
        w_timeout   = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_mul_valid = 1'b1;
                w_state_nxt = S_WAIT_RES;
            end
            S_WAIT_RES: begin
                // A real response wins over a coincident watchdog expiry.
                if (mul_ready) begin
                    w_load_res  = 1'b1;
                    w_state_nxt = S_HOLD;
                end else if (r_wd == '0) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (r_out_valid && out_ready) begin
                    w_release   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign mul_valid = w_mul_valid;

    // ------------------------------------------------------------------
    // Product classification (sign ignored)
    // ------------------------------------------------------------------
    assign w_exp = mul_result[30:23];
    assign w_man = mul_result[22:0];

    // w_class = {nan, inf, zero, subnormal}
    always_comb begin
        w_class = 4'b0000;
        if (w_exp == 8'hFF) begin
            w_class = (w_man != '0) ? 4'b1000 : 4'b0100;
        end else if (w_exp == 8'h00) begin
            w_class = (w_man != '0) ? 4'b0001 : 4'b0010;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mul_din1 <= '0;
            r_mul_din2 <= '0;
            r_tag      <= '0;
        end else if (w_pop) begin
            r_mul_din1 <= r_mem_a[r_rd_ptr];
            r_mul_din2 <= r_mem_b[r_rd_ptr];
            r_tag      <= r_mem_tag[r_rd_ptr];
        end
    end

    // Watchdog counts down from TIMEOUT starting the cycle after ISSUE;
    // it reaches zero in the (TIMEOUT+1)-th WAIT_RES cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wd <= '0;
        end else if (r_state == S_ISSUE) begin
            r_wd <= WD_LOAD;
        end else if (r_state == S_WAIT_RES && r_wd != '0) begin
            r_wd <= r_wd - WD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_tag    <= '0;
            r_out_flags  <= '0;
            r_err        <= 1'b0;
        end else begin
            if (w_load_res) begin
                r_out_valid  <= 1'b1;
                r_out_result <= mul_result;
                r_out_tag    <= r_tag;
                r_out_flags  <= {1'b0, w_class};
            end else if (w_timeout) begin
                r_out_valid  <= 1'b1;
                r_out_result <= QNAN;
                r_out_tag    <= r_tag;
                r_out_flags  <= TIMEOUT_FLG;
                r_err        <= 1'b1;
            end else if (w_release) begin
                r_out_valid  <= 1'b0;
            end
        end
    end

    assign mul_din1   = r_mul_din1;
    assign mul_din2   = r_mul_din2;
    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_tag    = r_out_tag;
    assign out_flags  = r_out_flags;
    assign err        = r_err;
    assign count      = r_count;

endmodule

// File: tb/tb_fpu_mul_issue.sv
`timescale 1ns/1ps
// Testbench for fpu_mul_issue: a behavioural multiplier stub answers issues,
// an input monitor pushes expected results into a scoreboard, and an output
// monitor pops and compares on each output handshake.
module tb_fpu_mul_issue;

    localparam int DEPTH   = 4;
    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 16;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   in_valid;
    logic                   in_ready;
    logic [31:0]            in_a;
    logic [31:0]            in_b;
    logic [TAG_W-1:0]       in_tag;
    logic [31:0]            mul_din1;
    logic [31:0]            mul_din2;
    logic                   mul_valid;
    logic [31:0]            mul_result;
    logic                   mul_ready;
    logic                   out_valid;
    logic                   out_ready;
    logic [31:0]            out_result;
    logic [TAG_W-1:0]       out_tag;
    logic [4:0]             out_flags;
    logic                   err;
    logic [$clog2(DEPTH):0] count;

    always #5 clk = ~clk;

    fpu_mul_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .mul_din1   (mul_din1),
        .mul_din2   (mul_din2),
        .mul_valid  (mul_valid),
        .mul_result (mul_result),
        .mul_ready  (mul_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_flags  (out_flags),
        .err        (err),
        .count      (count)
    );

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      res;
        logic [4:0]       flags;
    } exp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        mute;
    } req_t;

    exp_t sb_q[$];
    req_t req_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int mv_cyc = 0;
    int rdy_cyc = 0;
    int n_pulses = 0;
    int rdy_mode = 0;   // 0: always ready, 1: stalled, 2: random
    logic spur_en = 1'b0;
    logic drv_mute = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic is_inf(input logic [31:0] v);
        return v[30:0] == 31'h7F80_0000;
    endfunction

    function automatic logic is_zero(input logic [31:0] v);
        return v[30:0] == 31'h0;
    endfunction

    function automatic logic is_nan(input logic [31:0] v);
        return v[30:23] == 8'hFF && v[22:0] != 23'h0;
    endfunction

    // IEEE product for the operand mixes the bench uses (one operand +-1.0,
    // NaN/inf*0 specials, and 2.0*3.0).
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic s;
        s = a[31] ^ b[31];
        if (a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
        if ((is_inf(a) && is_zero(b)) || (is_zero(a) && is_inf(b))) return 32'hFFC0_0000;
        if (is_nan(a)) return a | 32'h0040_0000;
        if (is_nan(b)) return b | 32'h0040_0000;
        if (a[30:0] == 31'h3F80_0000) return {s, b[30:0]};
        if (b[30:0] == 31'h3F80_0000) return {s, a[30:0]};
        return {s, a[30:0] ^ b[30:0]};
    endfunction

    // {timeout, nan, inf, zero, subnormal}
    function automatic logic [4:0] classify(input logic [31:0] r);
        if (is_nan(r)) return 5'b01000;
        if (is_inf(r)) return 5'b00100;
        if (is_zero(r)) return 5'b00010;
        if (r[30:23] == 8'h00) return 5'b00001;
        return 5'b00000;
    endfunction

    function automatic logic [31:0] gen_val();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 5))
            0: v[30:0] = 31'h0;
            1: begin v[30:23] = 8'h00; if (v[22:0] == 23'h0) v[0] = 1'b1; end
            2: v[30:0] = 31'h7F80_0000;
            3: begin v[30:23] = 8'hFF; if (v[22:0] == 23'h0) v[5] = 1'b1; end
            default: if (v[30:23] == 8'hFF || v[30:23] == 8'h00) v[30:23] = 8'h80;
        endcase
        return v;
    endfunction

    // ---------------- input monitor ----------------
    always @(negedge clk) begin
        logic [31:0] r;
        exp_t e;
        if (reset && in_valid && in_ready) begin
            r = ref_mul(in_a, in_b);
            if (drv_mute) e = '{tag: in_tag, res: 32'h7FC0_0000, flags: 5'b11000};
            else          e = '{tag: in_tag, res: r, flags: classify(r)};
            sb_q.push_back(e);
            req_q.push_back('{a: in_a, b: in_b, mute: drv_mute});
        end
    end

    // ---------------- multiplier stub ----------------
    initial begin
        logic        st_pend;
        int          st_delay;
        logic [31:0] st_res;
        req_t        rq;
        st_pend    = 1'b0;
        st_delay   = 0;
        st_res     = '0;
        mul_ready  = 1'b0;
        mul_result = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                st_pend = 1'b0;
                req_q.delete();
            end else if (mul_valid) begin
                if (req_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL issue_unexpected: got mul_valid expected no queued request at %0t", $time);
                end else begin
                    rq = req_q.pop_front();
                    check("issue_din1", mul_din1, rq.a);
                    check("issue_din2", mul_din2, rq.b);
                    if (!rq.mute) begin
                        st_pend  = 1'b1;
                        st_delay = $urandom_range(0, 3);
                        st_res   = ref_mul(rq.a, rq.b);
                    end
                end
            end
            @(posedge clk);
            #1;
            mul_ready = 1'b0;
            if (reset && st_pend) begin
                if (st_delay == 0) begin
                    mul_ready  = 1'b1;
                    mul_result = st_res;
                    st_pend    = 1'b0;
                    rdy_cyc    = cyc;
                end else begin
                    st_delay--;
                end
            end else if (reset && spur_en && out_valid && $urandom_range(0, 3) == 0) begin
                // stray pulse while the DUT holds a result: must be ignored
                mul_ready  = 1'b1;
                mul_result = $urandom;
            end
        end
    end

    // ---------------- out_ready driver ----------------
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- issue pulse monitor ----------------
    always @(negedge clk) begin
        logic mv_prev;
        logic have_mv;
        if (!reset) begin
            mv_prev = 1'b0;
            have_mv = 1'b0;
        end else begin
            if (mv_prev) begin
                check("mul_valid_width", 32'(mul_valid), 32'h0);
            end else if (mul_valid) begin
                n_pulses++;
                if (have_mv) check("issue_spacing_ge4", 32'((cyc - mv_cyc) >= 4), 32'h1);
                mv_cyc  = cyc;
                have_mv = 1'b1;
            end
            mv_prev = mul_valid;
        end
    end

    // ---------------- output monitor / scoreboard ----------------
    logic exp_err = 1'b0;

    always @(negedge clk) begin
        logic             held;
        logic             ov_prev;
        logic [31:0]      s_res;
        logic [TAG_W-1:0] s_tag;
        logic [4:0]       s_flg;
        exp_t             e;
        if (!reset) begin
            held    = 1'b0;
            ov_prev = 1'b0;
            exp_err = 1'b0;
            sb_q.delete();
        end else begin
            if (out_valid && !ov_prev && sb_q.size() != 0) begin
                if (sb_q[0].flags[4]) check("timeout_latency", 32'(cyc - mv_cyc), 32'(TIMEOUT + 2));
                else                  check("result_latency", 32'(cyc - rdy_cyc), 32'h1);
            end
            if (out_valid) begin
                if (held) begin
                    check("stable_result", out_result, s_res);
                    check("stable_tag", 32'(out_tag), 32'(s_tag));
                    check("stable_flags", 32'(out_flags), 32'(s_flg));
                end
                if (out_ready) begin
                    if (sb_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL out_unexpected: got tag %h result %h expected no output at %0t",
                                 out_tag, out_result, $time);
                    end else begin
                        e = sb_q.pop_front();
                        if (e.flags[4]) exp_err = 1'b1;
                        check("out_result", out_result, e.res);
                        check("out_tag", 32'(out_tag), 32'(e.tag));
                        check("out_flags", 32'(out_flags), 32'(e.flags));
                        check("err", 32'(err), 32'(exp_err));
                    end
                    held = 1'b0;
                end else begin
                    held  = 1'b1;
                    s_res = out_result;
                    s_tag = out_tag;
                    s_flg = out_flags;
                end
            end else begin
                held = 1'b0;
            end
            ov_prev = out_valid;
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push(input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] t, input logic m);
        int k;
        k        = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_tag   = t;
        drv_mute = m;
        do begin
            @(negedge clk);
            k++;
        end while (!in_ready && k < 500);
        if (!in_ready) begin
            n_cmp++; n_err++;
            $display("FAIL push_wait: got in_ready 0 expected 1 within 500 cycles (tag %h)", t);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((sb_q.size() != 0 || out_valid) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("drain_done", 32'(sb_q.size() == 0 && !out_valid), 32'h1);
        @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int p0;
        logic [31:0] x;
        logic [31:0] y;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_tag   = '0;
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_count", 32'(count), 32'h0);
        check("rst_mul_valid", 32'(mul_valid), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_din1", mul_din1, 32'h0);
        check("rst_din2", mul_din2, 32'h0);
        check("rst_out_result", out_result, 32'h0);
        check("rst_out_tag", 32'(out_tag), 32'h0);
        check("rst_out_flags", 32'(out_flags), 32'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'h1);

        // single operation, request-path timing
        rdy_mode = 0;
        p0 = n_pulses;
        push(32'h4000_0000, 32'h4040_0000, 4'd5, 1'b0);
        @(negedge clk); check("t1_mv_cycle_T", 32'(mul_valid), 32'h0);
        @(negedge clk); check("t1_mv_cycle_T1", 32'(mul_valid), 32'h1);
        @(negedge clk); check("t1_mv_cycle_T2", 32'(mul_valid), 32'h0);
        @(posedge clk); #1;
        drain(100);
        check("t1_one_pulse", 32'(n_pulses - p0), 32'h1);

        // fill and full under stalled output
        rdy_mode = 1;
        spur_en  = 1'b1;
        for (int i = 0; i < 5; i++) push(32'h3F80_0000, 32'h4100_0000 + 32'(i), 4'(i), 1'b0);
        in_valid = 1'b1; in_a = 32'h3F80_0000; in_b = 32'h4100_0005; in_tag = 4'd5; drv_mute = 1'b0;
        repeat (8) @(negedge clk);
        check("full_count", 32'(count), 32'(DEPTH));
        check("full_in_ready", 32'(in_ready), 32'h0);
        check("full_out_valid", 32'(out_valid), 32'h1);
        rdy_mode = 0;
        @(posedge clk); #1;
        push(32'h3F80_0000, 32'h4100_0005, 4'd5, 1'b0);
        drain(300);

        // special values
        push(32'h7F80_0000, 32'h0000_0000, 4'd1, 1'b0);
        push(32'h0000_0001, 32'h3F80_0000, 4'd2, 1'b0);
        push(32'hBF80_0000, 32'h0000_0000, 4'd3, 1'b0);
        push(32'h3F80_0000, 32'hFF80_0000, 4'd4, 1'b0);
        drain(200);

        // randomized traffic with random backpressure and stray mul_ready
        rdy_mode = 2;
        for (int i = 0; i < 150; i++) begin
            x = $urandom_range(0, 1) ? 32'h3F80_0000 : 32'hBF80_0000;
            y = gen_val();
            if ($urandom_range(0, 9) == 0) begin
                x = 32'h7F80_0000; y = 32'h8000_0000;
            end
            if ($urandom_range(0, 1) == 0) push(x, y, 4'($urandom), 1'($urandom_range(0, 19) == 0));
            else                           push(y, x, 4'($urandom), 1'($urandom_range(0, 19) == 0));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        rdy_mode = 0;
        drain(3000);

        // watchdog: muted request followed by a normal one
        push(32'h4000_0000, 32'h4040_0000, 4'hA, 1'b1);
        push(32'h3F80_0000, 32'h4049_0FDB, 4'hB, 1'b0);
        drain(200);
        repeat (5) @(negedge clk);
        check("err_sticky", 32'(err), 32'h1);
        @(posedge clk); #1;

        // reset while WAIT_RES with requests queued
        push(32'h3F80_0000, 32'h4000_0000, 4'd7, 1'b1);
        push(32'h3F80_0000, 32'h4040_0000, 4'd8, 1'b0);
        push(32'h3F80_0000, 32'h4080_0000, 4'd9, 1'b0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_count", 32'(count), 32'h0);
        check("mid_rst_mul_valid", 32'(mul_valid), 32'h0);
        check("mid_rst_out_valid", 32'(out_valid), 32'h0);
        check("mid_rst_err", 32'(err), 32'h0);
        check("mid_rst_din1", mul_din1, 32'h0);
        check("mid_rst_din2", mul_din2, 32'h0);
        check("mid_rst_out_result", out_result, 32'h0);
        check("mid_rst_out_tag", 32'(out_tag), 32'h0);
        check("mid_rst_out_flags", 32'(out_flags), 32'h0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check("post_rst_out_valid", 32'(out_valid), 32'h0);
            check("post_rst_mul_valid", 32'(mul_valid), 32'h0);
        end
        check("post_rst_count", 32'(count), 32'h0);
        check("post_rst_in_ready", 32'(in_ready), 32'h1);
        @(posedge clk); #1;

        // normal operation after reset
        push(32'h4000_0000, 32'h4040_0000, 4'd6, 1'b0);
        drain(100);
        check("final_err_clear", 32'(err), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        n_err++;
        $display("FAIL global_time_limit: got still running expected finished by 500000 ns");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "time limit");
    end

endmodule
